// File: rtl/stopwatch_control.sv
// stopwatch_control: button front end for the stopwatch counter/display.
// Each raw button is synchronised (2 flops), debounced and edge-detected.
// The clean press pulses drive an IDLE/RUN/PAUSE/CLR state machine that
// produces a glitch-free run level and a fixed-width active-high clear pulse.
// Optional lap-hold logic is built only when STOPWATCH_CONTROL_LAP_HOLD_EN
// is defined; otherwise lap_hold is tied low and btn_lap is ignored.
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int CLEAR_PULSE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       run,
    output logic       clear,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    // Button index map: 0 = start, 1 = clear, 2 = lap (optional)
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press_vec;

    assign btn_raw[0] = btn_start;
    assign btn_raw[1] = btn_clear;
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
    assign btn_raw[2] = btn_lap;
`else
    // Lap button has no function in this build
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_prev_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Two-flop synchroniser for the asynchronous raw button
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: stable value flips only after DEBOUNCE_CYCLES consecutive mismatching cycles
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else if (sync2_reg == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            // Press detect: one-cycle registered pulse on a 0->1 of the stable value
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    stable_prev_reg <= 1'b0;
                    press_reg       <= 1'b0;
                end else begin
                    stable_prev_reg <= stable_reg;
                    press_reg       <= stable_reg & ~stable_prev_reg;
                end
            end

            assign press_vec[gi] = press_reg;
        end
    endgenerate

    logic start_press;
    logic clear_press;
    assign start_press = press_vec[0];
    assign clear_press = press_vec[1];

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        CLR   = 2'b11
    } state_t;

    state_t     state_reg;
    logic       run_reg;
    logic       clear_reg;
    logic [7:0] pulse_cnt_reg;

`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
    logic lap_press;
    logic lap_hold_reg;
    assign lap_press = press_vec[2];
`endif

    // Run/pause/clear state machine with registered outputs; presses in CLR are dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            run_reg       <= 1'b0;
            clear_reg     <= 1'b0;
            pulse_cnt_reg <= 8'd0;
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
            lap_hold_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
                    lap_hold_reg <= 1'b0;
`endif
                    // Clear wins over start when both arrive together
                    if (clear_press) begin
                        state_reg     <= CLR;
                        run_reg       <= 1'b0;
                        clear_reg     <= 1'b1;
                        pulse_cnt_reg <= 8'd0;
                    end else if (start_press) begin
                        state_reg <= RUN;
                        run_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    // Clear is ignored while counting; start alone decides
                    if (start_press) begin
                        state_reg <= PAUSE;
                        run_reg   <= 1'b0;
                    end
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
                    if (lap_press) begin
                        lap_hold_reg <= ~lap_hold_reg;
                    end
`endif
                end
                PAUSE: begin
                    if (clear_press) begin
                        state_reg     <= CLR;
                        run_reg       <= 1'b0;
                        clear_reg     <= 1'b1;
                        pulse_cnt_reg <= 8'd0;
                    end else if (start_press) begin
                        state_reg <= RUN;
                        run_reg   <= 1'b1;
                    end
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
                    // Lap in pause can only release the hold; clear entry also drops it
                    if (clear_press || lap_press) begin
                        lap_hold_reg <= 1'b0;
                    end
`endif
                end
                CLR: begin
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
                    lap_hold_reg <= 1'b0;
`endif
                    if (pulse_cnt_reg == 8'(CLEAR_PULSE_CYCLES - 1)) begin
                        state_reg     <= IDLE;
                        clear_reg     <= 1'b0;
                        pulse_cnt_reg <= 8'd0;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    run_reg       <= 1'b0;
                    clear_reg     <= 1'b0;
                    pulse_cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    assign run   = run_reg;
    assign clear = clear_reg;
    assign state = state_reg;

`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
    assign lap_hold = lap_hold_reg;
`else
    assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_control.sv
// Testbench for stopwatch_control (DEBOUNCE_CYCLES=4, CLEAR_PULSE_CYCLES=2).
// Stimulus pushes expected output changes {run,clear,lap_hold,state} with the
// edge number at which they must appear; a monitor pops and compares on every
// observed output change. Phase-end checks confirm steady values and that no
// expected change is still outstanding.
module tb_stopwatch_control;

    logic       clock;
    logic       reset_n;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       run;
    logic       clear;
    logic       lap_hold;
    logic [1:0] state;

    stopwatch_control #(
        .DEBOUNCE_CYCLES   (4),
        .CLEAR_PULSE_CYCLES(2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_lap  (btn_lap),
        .run      (run),
        .clear    (clear),
        .lap_hold (lap_hold),
        .state    (state)
    );

    typedef struct {
        logic [4:0] val;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic mon_en   = 1'b0;
    logic [4:0] prev_obs = 5'b0;

    // Output vector encodings {run, clear, lap_hold, state}
    localparam logic [4:0] V_IDLE  = 5'b0_0_0_00;
    localparam logic [4:0] V_RUN   = 5'b1_0_0_01;
    localparam logic [4:0] V_PAUSE = 5'b0_0_0_10;
    localparam logic [4:0] V_CLR   = 5'b0_1_0_11;
    localparam logic [4:0] V_RUNL  = 5'b1_0_1_01;
    localparam logic [4:0] V_PAUSEL= 5'b0_0_1_10;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Monitor: every output change must match the next expected entry and its edge
    always @(negedge clock) begin
        logic [4:0] cur;
        exp_t       e;
        cur = {run, clear, lap_hold, state};
        if (!mon_en) begin
            prev_obs = cur;
        end else if (cur !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: got=%b at edge %0d, required no change from %b",
                         cur, edge_cnt, prev_obs);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.val || edge_cnt != e.cyc) begin
                    failures++;
                    $display("FAIL output_change: got=%b at edge %0d, required=%b at edge %0d",
                             cur, edge_cnt, e.val, e.cyc);
                end else begin
                    $display("ok   output_change %b at edge %0d", cur, edge_cnt);
                end
            end
            prev_obs = cur;
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic [4:0] v, input int cyc);
        exp_t e;
        e.val = v;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Press the given buttons for 8 cycles, release, then idle 10 cycles.
    // Offsets are in spec edges relative to the first edge that samples the press.
    task automatic press(input string nm, input logic s, input logic c, input logic l,
                         input int n_exp, input logic [4:0] v1, input int o1,
                         input logic [4:0] v2, input int o2);
        int base;
        @(negedge clock);
        base = edge_cnt + 1;
        if (n_exp > 0) push_exp(v1, base + o1);
        if (n_exp > 1) push_exp(v2, base + o2);
        btn_start = s;
        btn_clear = c;
        btn_lap   = l;
        $display("stim %s at edge %0d", nm, base);
        repeat (8) @(negedge clock);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    // Steady-state check: outputs equal v and nothing is left in the queue
    task automatic check_steady(input string nm, input logic [4:0] v);
        logic [4:0] cur;
        cur = {run, clear, lap_hold, state};
        checks++;
        if (cur !== v || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: got=%b pending=%0d, required=%b pending=0",
                     nm, cur, exp_q.size(), v);
            exp_q.delete();
        end else begin
            $display("ok   %s outputs=%b", nm, cur);
        end
    endtask

    initial begin
        int base;
        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_steady("reset_state", V_IDLE);
        @(negedge clock);
        mon_en = 1'b1;
        repeat (20) @(negedge clock);
        check_steady("idle_20_cycles", V_IDLE);

        // Bounce: 3 high / 3 low for 30 cycles never debounces
        for (int i = 0; i < 5; i++) begin
            btn_start = 1'b1;
            repeat (3) @(negedge clock);
            btn_start = 1'b0;
            repeat (3) @(negedge clock);
        end
        repeat (10) @(negedge clock);
        check_steady("bounce_rejected", V_IDLE);

        // Long hold: RUN first at edge 7, nothing more while held or on release
        @(negedge clock);
        base = edge_cnt + 1;
        push_exp(V_RUN, base + 7);
        btn_start = 1'b1;
        $display("stim start_hold at edge %0d", base);
        repeat (20) @(negedge clock);
        btn_start = 1'b0;
        repeat (12) @(negedge clock);
        check_steady("held_start_single_press", V_RUN);

        // Second press pauses, then clear gives a 2-cycle pulse and returns to IDLE
        press("start_to_pause", 1, 0, 0, 1, V_PAUSE, 7, V_IDLE, 0);
        check_steady("paused", V_PAUSE);
        press("clear_from_pause", 0, 1, 0, 2, V_CLR, 7, V_IDLE, 9);
        check_steady("after_clear", V_IDLE);

        // Clear is ignored in RUN; start+clear together in PAUSE goes to CLR
        press("start_to_run", 1, 0, 0, 1, V_RUN, 7, V_IDLE, 0);
        press("clear_in_run", 0, 1, 0, 0, V_IDLE, 0, V_IDLE, 0);
        check_steady("clear_ignored_in_run", V_RUN);
        press("lap_in_run", 0, 0, 1, 0, V_IDLE, 0, V_IDLE, 0);
`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
        press("lap_in_run_again", 0, 0, 1, 0, V_IDLE, 0, V_IDLE, 0);
`endif
        check_steady("lap_net_no_effect", V_RUN);
        press("start_to_pause2", 1, 0, 0, 1, V_PAUSE, 7, V_IDLE, 0);
        press("start_and_clear_in_pause", 1, 1, 0, 2, V_CLR, 7, V_IDLE, 9);
        check_steady("simultaneous_clear_wins", V_IDLE);

        // Start+clear together from IDLE also lands in CLR
        press("start_and_clear_in_idle", 1, 1, 0, 2, V_CLR, 7, V_IDLE, 9);
        check_steady("idle_simultaneous", V_IDLE);

        // Reset dropped after one clear cycle clears outputs with no clock edge
        press("start_to_run3", 1, 0, 0, 1, V_RUN, 7, V_IDLE, 0);
        press("start_to_pause3", 1, 0, 0, 1, V_PAUSE, 7, V_IDLE, 0);
        @(negedge clock);
        base = edge_cnt + 1;
        push_exp(V_CLR, base + 7);
        btn_clear = 1'b1;
        $display("stim clear_then_reset at edge %0d", base);
        repeat (8) @(negedge clock);
        #2;
        mon_en    = 1'b0;
        btn_clear = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_steady("async_reset_mid_clr", V_IDLE);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        repeat (20) @(negedge clock);
        check_steady("no_clear_after_reset", V_IDLE);
        press("start_after_reset", 1, 0, 0, 1, V_RUN, 7, V_IDLE, 0);
        check_steady("run_after_reset", V_RUN);

`ifdef STOPWATCH_CONTROL_LAP_HOLD_EN
        // Lap toggles in RUN, survives pause, and is dropped on CLR entry
        press("lap_on", 0, 0, 1, 1, V_RUNL, 7, V_IDLE, 0);
        press("lap_off", 0, 0, 1, 1, V_RUN, 7, V_IDLE, 0);
        press("lap_on2", 0, 0, 1, 1, V_RUNL, 7, V_IDLE, 0);
        press("pause_with_lap", 1, 0, 0, 1, V_PAUSEL, 7, V_IDLE, 0);
        press("clear_drops_lap", 0, 1, 0, 2, V_CLR, 7, V_IDLE, 9);
        check_steady("lap_cleared", V_IDLE);
`endif

        repeat (5) @(negedge clock);
        check_steady("final_no_pending", {run, clear, lap_hold, state} === 5'bxxxxx ? 5'b0 : prev_obs);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
